axis_1553_encoder: RTL and testbench

MIL-STD-1553 word encoder with an AXI-Stream slave input. Each accepted 16-bit word is serialised at 1 Mbit/s as a 3-bit-time sync, 16 Manchester II data bits (MSB first) and an odd parity bit. The word is driven on a differential pair with an output enable. The block sits between a host AXI-Stream source and the 1553 bus transceiver.

---
 rtl/axis_1553_encoder.sv | 201 ++++++++++++++++++++
 tb/tb_axis_1553_encoder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/axis_1553_encoder.sv
// MIL-STD-1553 word encoder fed by an AXI-Stream slave.
// Each accepted word is sent as sync, 16 Manchester II data bits (MSB first) and odd parity.
// Optional inter-word gap support is compiled in with `define UTIL_AXIS_1553_ENCODER_GAP_EN.
module axis_1553_encoder #(
   parameter int unsigned clock_speed = 2000000
) (
   input  logic        aclk,
   input  logic        arst,
   input  logic [15:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic [7:0]  s_axis_tuser,
   output logic        s_axis_tready,
   output logic [1:0]  diff,
   output logic        en_diff
);

   // Cycles per half bit time.
   localparam int unsigned H    = clock_speed / 2000000;
   localparam int unsigned CntW = $clog2(3 * H);

   localparam logic [CntW-1:0] HalfLast = CntW'(H - 1);
   localparam logic [CntW-1:0] SyncLast = CntW'(3 * H - 1);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StSync   = 3'd1;
   localparam logic [2:0] StData   = 3'd2;
   localparam logic [2:0] StParity = 3'd3;
`ifdef UTIL_AXIS_1553_ENCODER_GAP_EN
   localparam logic [2:0] StGap    = 3'd4;
   localparam int unsigned GapW    = $clog2(30 * H);
`endif

   logic [2:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            half_q, half_d;
   logic [3:0]      bit_q, bit_d;
   logic [15:0]     data_q, data_d;
   logic            cmd_q, cmd_d;
   logic            par_q, par_d;
   logic            tready_q, tready_d;
   logic [1:0]      diff_q, diff_d;
   logic            en_q, en_d;
   logic            level;
`ifdef UTIL_AXIS_1553_ENCODER_GAP_EN
   logic [3:0]      gap_q, gap_d;
   logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
   logic [31:0]     gap_len;
   logic [GapW-1:0] gap_last;
   logic            unused_tuser;
   assign unused_tuser = s_axis_tuser[4];
`else
   logic            unused_tuser;
   assign unused_tuser = ^s_axis_tuser[4:0];
`endif

   // Sequencer: half-bit timing, bit index and state transitions.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      half_d  = half_q;
      bit_d   = bit_q;
      data_d  = data_q;
      cmd_d   = cmd_q;
      par_d   = par_q;
`ifdef UTIL_AXIS_1553_ENCODER_GAP_EN
      gap_d     = gap_q;
      gap_cnt_d = gap_cnt_q;
      gap_len   = 32'(gap_q) * 2 * H;
      gap_last  = GapW'(gap_len - 1);
`endif
      case (state_q)
         StIdle: begin
            if (s_axis_tvalid && tready_q) begin
               data_d  = s_axis_tdata;
               cmd_d   = (s_axis_tuser[7:5] == 3'b100);
               par_d   = ~^s_axis_tdata;
`ifdef UTIL_AXIS_1553_ENCODER_GAP_EN
               gap_d   = s_axis_tuser[3:0];
`endif
               state_d = StSync;
               cnt_d   = '0;
               half_d  = 1'b0;
            end
         end
         StSync: begin
            if (cnt_q == SyncLast) begin
               cnt_d  = '0;
               half_d = ~half_q;
               if (half_q) begin
                  state_d = StData;
                  bit_d   = 4'd15;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StData: begin
            if (cnt_q == HalfLast) begin
               cnt_d  = '0;
               half_d = ~half_q;
               if (half_q) begin
                  if (bit_q == 4'd0) state_d = StParity;
                  else               bit_d   = bit_q - 4'd1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StParity: begin
            if (cnt_q == HalfLast) begin
               cnt_d  = '0;
               half_d = ~half_q;
               if (half_q) begin
`ifdef UTIL_AXIS_1553_ENCODER_GAP_EN
                  if (gap_q != 4'd0) begin
                     state_d   = StGap;
                     gap_cnt_d = '0;
                  end else begin
                     state_d = StIdle;
                  end
`else
                  state_d = StIdle;
`endif
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
`ifdef UTIL_AXIS_1553_ENCODER_GAP_EN
         StGap: begin
            if (gap_cnt_q == gap_last) state_d   = StIdle;
            else                       gap_cnt_d = gap_cnt_q + GapW'(1);
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // Output decode from next state so every output is a plain register.
   always_comb begin
      level    = 1'b0;
      en_d     = 1'b0;
      tready_d = (state_d == StIdle);
      case (state_d)
         StSync: begin
            level = cmd_d ? ~half_d : half_d;
            en_d  = 1'b1;
         end
         StData: begin
            level = data_d[bit_d] ? ~half_d : half_d;
            en_d  = 1'b1;
         end
         StParity: begin
            level = par_d ? ~half_d : half_d;
            en_d  = 1'b1;
         end
         default: level = 1'b0;
      endcase
      diff_d = en_d ? (level ? 2'b10 : 2'b01) : 2'b00;
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         half_q   <= 1'b0;
         bit_q    <= 4'd0;
         data_q   <= 16'd0;
         cmd_q    <= 1'b0;
         par_q    <= 1'b0;
         tready_q <= 1'b0;
         diff_q   <= 2'b00;
         en_q     <= 1'b0;
`ifdef UTIL_AXIS_1553_ENCODER_GAP_EN
         gap_q     <= 4'd0;
         gap_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         half_q   <= half_d;
         bit_q    <= bit_d;
         data_q   <= data_d;
         cmd_q    <= cmd_d;
         par_q    <= par_d;
         tready_q <= tready_d;
         diff_q   <= diff_d;
         en_q     <= en_d;
`ifdef UTIL_AXIS_1553_ENCODER_GAP_EN
         gap_q     <= gap_d;
         gap_cnt_q <= gap_cnt_d;
`endif
      end
   end

   assign s_axis_tready = tready_q;
   assign diff          = diff_q;
   assign en_diff       = en_q;

endmodule

// File: tb/tb_axis_1553_encoder.sv
// Self-checking bench for axis_1553_encoder at 20 MHz (H = 10).
// Expected line levels come from a half-bit level table built from the word format.
module tb_axis_1553_encoder;

   localparam int unsigned ClockSpeed = 20000000;
   localparam int unsigned H          = ClockSpeed / 2000000;

   logic        aclk = 1'b0;
   logic        arst = 1'b1;
   logic [15:0] s_axis_tdata = 16'd0;
   logic        s_axis_tvalid = 1'b0;
   logic [7:0]  s_axis_tuser = 8'd0;
   logic        s_axis_tready;
   logic [1:0]  diff;
   logic        en_diff;

   int checks   = 0;
   int failures = 0;

   always #5 aclk = ~aclk;

   axis_1553_encoder #(
      .clock_speed(ClockSpeed)
   ) dut (
      .aclk          (aclk),
      .arst          (arst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tready (s_axis_tready),
      .diff          (diff),
      .en_diff       (en_diff)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a word at a falling edge; it is taken on the following rising edge.
   task automatic start_word(input logic [15:0] d, input logic [7:0] u);
      @(negedge aclk);
      check("ready_before_word", 16'(s_axis_tready), 16'h1);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tuser  = u;
   endtask

   // Check the whole bus waveform of one word, the gap and the idle cycle after it.
   task automatic expect_word(input logic [15:0] d, input logic [7:0] u, input bit stream,
                              input bit keep_valid, input logic [15:0] next_d);
      logic       lv [40];
      logic       cmd;
      logic [1:0] exp_diff;
      int         g;
      cmd = (u[7:5] == 3'b100);
      for (int k = 0; k < 3; k++) begin
         lv[k]     = cmd;
         lv[k + 3] = !cmd;
      end
      for (int b = 0; b < 16; b++) begin
         lv[6 + 2 * b] = d[15 - b];
         lv[7 + 2 * b] = !d[15 - b];
      end
      lv[38] = ~^d;
      lv[39] = ^d;
`ifdef UTIL_AXIS_1553_ENCODER_GAP_EN
      g = int'(u[3:0]);
`else
      g = 0;
`endif
      for (int i = 0; i < 40 * H; i++) begin
         @(negedge aclk);
         exp_diff = lv[i / H] ? 2'b10 : 2'b01;
         check($sformatf("diff_%04h_c%0d", d, i), 16'(diff), 16'(exp_diff));
         check($sformatf("en_%04h_c%0d", d, i), 16'(en_diff), 16'h1);
         check($sformatf("rdy_%04h_c%0d", d, i), 16'(s_axis_tready), 16'h0);
         if (stream) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = next_d;
         end else begin
            s_axis_tvalid = 1'($urandom_range(0, 1));
            s_axis_tdata  = 16'($urandom);
            s_axis_tuser  = 8'($urandom);
         end
      end
      for (int i = 0; i < 2 * int'(H) * g; i++) begin
         @(negedge aclk);
         check($sformatf("gap_diff_%04h_c%0d", d, i), 16'(diff), 16'h0);
         check($sformatf("gap_en_%04h_c%0d", d, i), 16'(en_diff), 16'h0);
         check($sformatf("gap_rdy_%04h_c%0d", d, i), 16'(s_axis_tready), 16'h0);
      end
      @(negedge aclk);
      check($sformatf("idle_diff_%04h", d), 16'(diff), 16'h0);
      check($sformatf("idle_en_%04h", d), 16'(en_diff), 16'h0);
      check($sformatf("idle_rdy_%04h", d), 16'(s_axis_tready), 16'h1);
      if (!keep_valid) s_axis_tvalid = 1'b0;
   endtask

   initial begin
      logic [15:0] d;
      logic [7:0]  u;

      // Reset behaviour.
      #50;
      check("rst_ready", 16'(s_axis_tready), 16'h0);
      check("rst_diff", 16'(diff), 16'h0);
      check("rst_en", 16'(en_diff), 16'h0);
      #52;
      arst = 1'b0;
      check("ready_at_release", 16'(s_axis_tready), 16'h0);
      @(posedge aclk);
      #1;
      check("ready_after_release", 16'(s_axis_tready), 16'h1);

      // Directed words: command sync, data sync, parity 0.
      start_word(16'hFFFF, 8'h80);
      expect_word(16'hFFFF, 8'h80, 1'b0, 1'b0, 16'h0);
      start_word(16'h0000, 8'h40);
      expect_word(16'h0000, 8'h40, 1'b0, 1'b0, 16'h0);
      start_word(16'h0001, 8'h40);
      expect_word(16'h0001, 8'h40, 1'b0, 1'b0, 16'h0);

      // Random words and control, with garbage on the inputs while busy.
      for (int n = 0; n < 6; n++) begin
         d = 16'($urandom);
         u = {($urandom_range(0, 1) != 0) ? 3'b100 : 3'($urandom), 1'($urandom),
              4'($urandom_range(0, 3))};
         start_word(d, u);
         expect_word(d, u, 1'b0, 1'b0, 16'h0);
      end

      // Streaming with tvalid held high and tdata advancing on each handshake.
      start_word(16'hFFFF, 8'h8F);
      expect_word(16'hFFFF, 8'h8F, 1'b1, 1'b1, 16'h0000);
      expect_word(16'h0000, 8'h8F, 1'b1, 1'b1, 16'h0001);
      expect_word(16'h0001, 8'h8F, 1'b1, 1'b0, 16'h0002);

      // Reset in the middle of a word.
      start_word(16'hA5A5, 8'h80);
      repeat (150) begin
         @(negedge aclk);
         s_axis_tvalid = 1'b0;
      end
      check("en_before_reset", 16'(en_diff), 16'h1);
      #2;
      arst = 1'b1;
      #1;
      check("midrst_diff", 16'(diff), 16'h0);
      check("midrst_en", 16'(en_diff), 16'h0);
      check("midrst_ready", 16'(s_axis_tready), 16'h0);
      @(negedge aclk);
      arst = 1'b0;
      @(negedge aclk);
      check("post_rst_ready", 16'(s_axis_tready), 16'h1);
      check("post_rst_diff", 16'(diff), 16'h0);
      start_word(16'h1234, 8'h40);
      expect_word(16'h1234, 8'h40, 1'b0, 1'b0, 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
